// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation encodings, FSM states,
// iterative-unit mode select and a decode helper for multi-cycle operations.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_DIVU = 4'd12,
        ALU_REM  = 4'd13,
        ALU_REMU = 4'd14
    } alu_ctrl;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state;

    typedef enum logic {
        ITER_MUL,
        ITER_DIV
    } iter_mode;

    // Operations that go through the shift-add / restoring-divide unit.
    function automatic logic is_iterative(input alu_ctrl op);
        case (op)
            ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between operand fetch, the sequential ALU and
// writeback. The master side issues requests and consumes results.
interface seq_alu_if #(
    parameter int WIDTH = 32
) ();
    import seq_alu_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    alu_ctrl          op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             eq;
    logic             busy;

    modport master (
        output flush, in_valid, op, op1, op2, out_ready,
        input  in_ready, out_valid, result, eq, busy
    );

    modport slave (
        input  flush, in_valid, op, op1, op2, out_ready,
        output in_ready, out_valid, result, eq, busy
    );

endinterface

// File: rtl/seq_alu_iter_unit.sv
// Iterative multiply/divide engine. One WIDTH-bit accumulator doubles as the
// product accumulator (multiply) and the partial remainder (divide); the q
// register holds the multiplier or the dividend-turning-quotient. The first
// step is folded into the start cycle so the last of WIDTH steps lands one
// cycle before the done pulse is seen by the controller.
module seq_alu_iter_unit
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  iter_mode         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    iter_mode         mode_r;
    logic [CW-1:0]    cnt;
    logic             running;

    logic [WIDTH-1:0] src_acc;
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] src_d;
    iter_mode         src_mode;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_acc;
    logic [WIDTH-1:0] nxt_q;
    logic [WIDTH-1:0] nxt_d;

    // One shift-add or restoring-divide step, taken from fresh operands on start.
    always_comb begin
        src_acc  = start ? '0 : acc;
        src_q    = start ? a : q;
        src_d    = start ? b : d;
        src_mode = start ? mode : mode_r;
        trial    = {src_acc, src_q[WIDTH-1]};
        diff     = trial - {1'b0, src_d};
        nxt_acc  = src_acc;
        nxt_q    = src_q;
        nxt_d    = src_d;
        if (src_mode == ITER_MUL) begin
            nxt_acc = src_acc + (src_q[0] ? src_d : '0);
            nxt_q   = src_q >> 1;
            nxt_d   = src_d << 1;
        end else if (!diff[WIDTH]) begin
            nxt_acc = diff[WIDTH-1:0];
            nxt_q   = {src_q[WIDTH-2:0], 1'b1};
        end else begin
            nxt_acc = trial[WIDTH-1:0];
            nxt_q   = {src_q[WIDTH-2:0], 1'b0};
        end
    end

    // Step registers and iteration count; done pulses once after the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            q       <= '0;
            d       <= '0;
            mode_r  <= ITER_MUL;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || running) begin
                acc    <= nxt_acc;
                q      <= nxt_q;
                d      <= nxt_d;
                mode_r <= src_mode;
                cnt    <= start ? CW'(1) : cnt + CW'(1);
                if (!start && cnt == CW'(WIDTH - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    running <= 1'b1;
                end
            end
        end
    end

    assign quotient  = q;
    assign remainder = acc;
    assign product   = acc;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU. Single-cycle ops and divide corner cases
// complete straight from IDLE; multiply/divide/remainder run on magnitudes in
// the iterative unit and get their sign restored here. Results are held in
// DONE until the consumer takes them.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state         state;
    alu_state         next_state;
    logic             in_ready_c;
    logic             accept;
    logic             iter_start;

    logic             is_div;
    logic             signed_div;
    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] imm_res;
    logic [SHW-1:0]   shamt;
    iter_mode         unit_mode;

    alu_ctrl          op_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] post_res;

    logic             iter_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] product;

    logic             out_valid_r;
    logic             busy_r;
    logic             eq_r;
    logic [WIDTH-1:0] result_r;

    // Readiness depends only on state and flush, never on in_valid.
    always_comb begin
        in_ready_c = (state == IDLE) && !bus.flush;
        accept     = bus.in_valid && in_ready_c;
    end

    // Decode the incoming request: single-cycle result, divide corner cases, magnitudes.
    always_comb begin
        shamt      = bus.op2[SHW-1:0];
        is_div     = (bus.op == ALU_DIV) || (bus.op == ALU_DIVU) ||
                     (bus.op == ALU_REM) || (bus.op == ALU_REMU);
        signed_div = (bus.op == ALU_DIV) || (bus.op == ALU_REM);
        op1_neg    = signed_div && bus.op1[WIDTH-1];
        op2_neg    = signed_div && bus.op2[WIDTH-1];
        mag1       = op1_neg ? -bus.op1 : bus.op1;
        mag2       = op2_neg ? -bus.op2 : bus.op2;
        div_zero   = is_div && (bus.op2 == '0);
        div_ovf    = signed_div && (bus.op1 == SMIN) && (bus.op2 == '1);
        special    = div_zero || div_ovf;
        unit_mode  = (bus.op == ALU_MUL) ? ITER_MUL : ITER_DIV;

        special_res = '0;
        if (div_zero) begin
            special_res = ((bus.op == ALU_DIV) || (bus.op == ALU_DIVU)) ? '1 : bus.op1;
        end else if (div_ovf) begin
            special_res = (bus.op == ALU_DIV) ? bus.op1 : '0;
        end

        alu_res = '0;
        case (bus.op)
            ALU_ADD:  alu_res = bus.op1 + bus.op2;
            ALU_SUB:  alu_res = bus.op1 - bus.op2;
            ALU_AND:  alu_res = bus.op1 & bus.op2;
            ALU_OR:   alu_res = bus.op1 | bus.op2;
            ALU_XOR:  alu_res = bus.op1 ^ bus.op2;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.op1 < bus.op2)};
            ALU_SLL:  alu_res = bus.op1 << shamt;
            ALU_SRL:  alu_res = bus.op1 >> shamt;
            ALU_SRA:  alu_res = $signed(bus.op1) >>> shamt;
            default:  alu_res = '0;
        endcase

        imm_res = special ? special_res : alu_res;
    end

    // Restore signs on the raw unit outputs for the captured operation.
    always_comb begin
        post_res = '0;
        case (op_r)
            ALU_MUL:  post_res = product;
            ALU_DIV:  post_res = neg_q_r ? -quotient : quotient;
            ALU_DIVU: post_res = quotient;
            ALU_REM:  post_res = neg_r_r ? -remainder : remainder;
            ALU_REMU: post_res = remainder;
            default:  post_res = '0;
        endcase
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        next_state = state;
        iter_start = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_iterative(bus.op) && !special) begin
                        next_state = BUSY;
                        iter_start = 1'b1;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            BUSY: begin
                if (iter_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (bus.flush) begin
            next_state = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Remember what the iterative unit is computing and how to fix its sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= ALU_ADD;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (iter_start) begin
            op_r    <= bus.op;
            neg_q_r <= op1_neg ^ op2_neg;
            neg_r_r <= op1_neg;
        end
    end

    // Registered outputs; result and eq only change on accept or iteration end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            eq_r        <= 1'b0;
            result_r    <= '0;
        end else begin
            out_valid_r <= (next_state == DONE);
            busy_r      <= (next_state == BUSY);
            if (accept) begin
                eq_r <= (bus.op1 == bus.op2);
                if (!iter_start) begin
                    result_r <= imm_res;
                end
            end else if ((state == BUSY) && iter_done && !bus.flush) begin
                result_r <= post_res;
            end
        end
    end

    seq_alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (bus.flush),
        .start     (iter_start),
        .mode      (unit_mode),
        .a         (mag1),
        .b         (mag2),
        .done      (iter_done),
        .quotient  (quotient),
        .remainder (remainder),
        .product   (product)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.eq        = eq_r;
    assign bus.result    = result_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH = 32: a table of single requests with
// hand-computed results and latencies, plus sequences for back-pressure,
// flush and asynchronous reset in the middle of a divide.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam alu_ctrl OP_BAD = alu_ctrl'(4'hF);

    typedef struct {
        alu_ctrl     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        eq;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    vec_t        vecs[$];
    logic [31:0] r;
    logic        e;
    int          lat;
    int          bn;
    int          n;
    string       tag;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck design still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request with out_ready high; report result, eq, latency and busy cycles.
    task automatic applyStimulus(input alu_ctrl op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic eq_o,
                                 output int lat_o, output int busy_o);
        int waited;
        res    = '0;
        eq_o   = 1'b0;
        lat_o  = 0;
        busy_o = 0;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        bus.op        = op;
        bus.op1       = a;
        bus.op2       = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                lat_o = k;
                res   = bus.result;
                eq_o  = bus.eq;
                break;
            end
            if (bus.busy) busy_o++;
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = ALU_ADD;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b0;

        vecs.push_back('{ALU_ADD,  32'd5,          32'd7,          32'd12,         1'b0, 1});
        vecs.push_back('{ALU_SUB,  32'd3,          32'd3,          32'd0,          1'b1, 1});
        vecs.push_back('{ALU_AND,  32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   1'b0, 1});
        vecs.push_back('{ALU_OR,   32'h0000F0F0,   32'h00000F0F,   32'h0000FFFF,   1'b0, 1});
        vecs.push_back('{ALU_XOR,  32'hFF00FF00,   32'hFFFF0000,   32'h00FFFF00,   1'b0, 1});
        vecs.push_back('{ALU_SRA,  32'h80000000,   32'h00000024,   32'hF8000000,   1'b0, 1});
        vecs.push_back('{ALU_SLT,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1});
        vecs.push_back('{ALU_SLTU, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1});
        vecs.push_back('{ALU_SLL,  32'd1,          32'h0000003F,   32'h80000000,   1'b0, 1});
        vecs.push_back('{ALU_SRL,  32'h80000000,   32'h00000021,   32'h40000000,   1'b0, 1});
        vecs.push_back('{ALU_ADD,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1});
        vecs.push_back('{OP_BAD,   32'd5,          32'd5,          32'd0,          1'b1, 1});
        vecs.push_back('{ALU_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0, 33});
        vecs.push_back('{ALU_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{ALU_MUL,  32'h0000FFFF,   32'h00010001,   32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{ALU_MUL,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b1, 33});
        vecs.push_back('{ALU_DIVU, 32'd100,        32'd7,          32'd14,         1'b0, 33});
        vecs.push_back('{ALU_REMU, 32'd100,        32'd7,          32'd2,          1'b0, 33});
        vecs.push_back('{ALU_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, 33});
        vecs.push_back('{ALU_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          1'b0, 33});
        vecs.push_back('{ALU_DIV,  32'h80000000,   32'd2,          32'hC0000000,   1'b0, 33});
        vecs.push_back('{ALU_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{ALU_DIVU, 32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b0, 1});
        vecs.push_back('{ALU_REMU, 32'h00001234,   32'd0,          32'h00001234,   1'b0, 1});
        vecs.push_back('{ALU_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1'b0, 1});
        vecs.push_back('{ALU_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1'b0, 1});
        vecs.push_back('{ALU_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 1});
        vecs.push_back('{ALU_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0, 1});

        repeat (3) @(negedge clk);
        checkOutput("reset in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset result",    bus.result,         32'd0);
        checkOutput("reset eq",        32'(bus.eq),        32'd0);
        checkOutput("reset busy",      32'(bus.busy),      32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, r, e, lat, bn);
            tag = $sformatf("v%0d op%0d", i, int'(vecs[i].op));
            checkOutput({tag, " result"},  r,        vecs[i].res);
            checkOutput({tag, " eq"},      32'(e),   32'(vecs[i].eq));
            checkOutput({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
            checkOutput({tag, " busy"},    32'(bn),  (vecs[i].lat == 33) ? 32'd32 : 32'd0);
        end

        // Back-pressure: result held while out_ready is low, queued request waits.
        @(negedge clk);
        bus.op = ALU_ADD; bus.op1 = 32'd9; bus.op2 = 32'd9;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold first valid", 32'(bus.out_valid), 32'd1);
        bus.op = ALU_SUB; bus.op1 = 32'd10; bus.op2 = 32'd4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d result", k),    bus.result,         32'd18);
            checkOutput($sformatf("hold%0d eq", k),        32'(bus.eq),        32'd1);
            checkOutput($sformatf("hold%0d in_ready", k),  32'(bus.in_ready),  32'd0);
            checkOutput($sformatf("hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("queued out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("queued result",    bus.result,         32'd6);
        checkOutput("queued eq",        32'(bus.eq),        32'd0);

        // Flush while a result is held in DONE.
        @(negedge clk);
        bus.op = ALU_ADD; bus.op1 = 32'd1; bus.op2 = 32'd2;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("done flush pre valid", 32'(bus.out_valid), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("done flush valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;
        #1;
        checkOutput("done flush in_ready", 32'(bus.in_ready), 32'd1);

        // Flush together with in_valid must not accept.
        @(negedge clk);
        bus.op = ALU_ADD; bus.op1 = 32'd4; bus.op2 = 32'd4;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b1;
        #1;
        checkOutput("flush masks in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("flush no accept valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush no accept busy",  32'(bus.busy),      32'd0);
        bus.flush = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("after flush valid",  32'(bus.out_valid), 32'd1);
        checkOutput("after flush result", bus.result,         32'd8);
        checkOutput("after flush eq",     32'(bus.eq),        32'd1);

        // Flush on the tenth BUSY cycle of a divide.
        @(negedge clk);
        bus.op = ALU_DIVU; bus.op1 = 32'd1000; bus.op2 = 32'd3;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.busy) n++;
        end
        checkOutput("busy before flush", 32'(n), 32'd10);
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("busy after flush", 32'(bus.busy), 32'd0);
        bus.flush = 1'b0;
        #1;
        checkOutput("idle after flush", 32'(bus.in_ready), 32'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        checkOutput("no valid after flush", 32'(n), 32'd0);

        // Asynchronous reset in the middle of a signed divide.
        @(negedge clk);
        bus.op = ALU_DIV; bus.op1 = 32'd100; bus.op2 = 32'd100;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("mid div busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async rst busy",      32'(bus.busy),      32'd0);
        checkOutput("async rst result",    bus.result,         32'd0);
        checkOutput("async rst eq",        32'(bus.eq),        32'd0);
        checkOutput("async rst in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(ALU_ADD, 32'd20, 32'd22, r, e, lat, bn);
        checkOutput("post rst result",  r,        32'd42);
        checkOutput("post rst latency", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
